// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (CPU / loader) arbiter in front of a single-ported
// synchronous data memory. It issues one memory command per cycle and grants in
// the same cycle. The loader can take exclusive ownership through l_lock.
// Read data returns one cycle after the grant and goes to the granted port.
// A saturating counter records cycles in which a request waited.

module dmem_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 9,
   parameter int RR_MODE = 1
) (
   input  logic              clk,
   input  logic              rst,
   // CPU port
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   // loader / debug port
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   input  logic              l_lock,
   output logic              l_gnt,
   output logic              l_rvalid,
   output logic [DATA_W-1:0] l_rdata,
   // memory side
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   // statistics
   output logic [7:0]        stall_cnt,
   input  logic              cnt_clr
);

   typedef enum logic [0:0] {
      ST_SHARED = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   // Last-owner encoding. Reset value is the loader, so that the CPU wins the
   // first round-robin conflict.
   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_LDR = 1'b1;

   state_t      state_r;
   state_t      state_nxt_s;
   logic        last_owner_r;
   logic        last_owner_nxt_s;
   logic        c_gnt_s;
   logic        l_gnt_s;
   logic        deny_s;
   logic        c_rvalid_r;
   logic        l_rvalid_r;
   logic [7:0]  stall_cnt_r;

   // Saturating 8-bit increment used by the stall counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] val);
      logic [7:0] res;
      if (val == 8'hFF) begin
         res = 8'hFF;
      end else begin
         res = val + 8'd1;
      end
      return res;
   endfunction

   // Round-robin pick on a conflict: returns 1 when the CPU should win.
   function automatic logic rr_pick_cpu(input logic last_owner);
      logic res;
      if (last_owner == OWNER_LDR) begin
         res = 1'b1;
      end else begin
         res = 1'b0;
      end
      return res;
   endfunction

   // Arbitration and next-state logic. No grant is issued while reset is high.
   always_comb begin
      c_gnt_s     = 1'b0;
      l_gnt_s     = 1'b0;
      state_nxt_s = state_r;
      if (rst) begin
         state_nxt_s = ST_SHARED;
      end else begin
         case (state_r)
            ST_SHARED: begin
               if (c_req && l_req) begin
                  if (RR_MODE != 32'sd0) begin
                     if (rr_pick_cpu(last_owner_r)) begin
                        c_gnt_s = 1'b1;
                     end else begin
                        l_gnt_s = 1'b1;
                     end
                  end else begin
                     c_gnt_s = 1'b1;
                  end
               end else if (c_req) begin
                  c_gnt_s = 1'b1;
               end else if (l_req) begin
                  l_gnt_s = 1'b1;
               end else begin
                  c_gnt_s = 1'b0;
               end
               // Ownership is taken only by an actual loader grant with lock set.
               if (l_gnt_s && l_lock) begin
                  state_nxt_s = ST_LOCKED;
               end else begin
                  state_nxt_s = ST_SHARED;
               end
            end
            ST_LOCKED: begin
               // CPU is blocked for the whole locked period, including the
               // cycle in which the loader drops l_lock.
               l_gnt_s = l_req;
               if (!l_lock) begin
                  state_nxt_s = ST_SHARED;
               end else begin
                  state_nxt_s = ST_LOCKED;
               end
            end
            default: begin
               state_nxt_s = ST_SHARED;
            end
         endcase
      end
   end

   // Last-owner tracking: follows every grant and holds otherwise.
   always_comb begin
      last_owner_nxt_s = last_owner_r;
      if (c_gnt_s) begin
         last_owner_nxt_s = OWNER_CPU;
      end else if (l_gnt_s) begin
         last_owner_nxt_s = OWNER_LDR;
      end else begin
         last_owner_nxt_s = last_owner_r;
      end
   end

   // A cycle counts as a stall when any asserted request goes ungranted.
   always_comb begin
      deny_s = (c_req && !c_gnt_s) || (l_req && !l_gnt_s);
   end

   // Memory command mux: the granted port drives the command. With no grant
   // the write enable stays low and address/data are parked at zero.
   always_comb begin
      m_en    = c_gnt_s | l_gnt_s;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      if (c_gnt_s) begin
         m_we    = c_we;
         m_addr  = c_addr;
         m_wdata = c_wdata;
      end else if (l_gnt_s) begin
         m_we    = l_we;
         m_addr  = l_addr;
         m_wdata = l_wdata;
      end else begin
         m_we    = 1'b0;
      end
   end

   // FSM state and last-owner registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_SHARED;
         last_owner_r <= OWNER_LDR;
      end else begin
         state_r      <= state_nxt_s;
         last_owner_r <= last_owner_nxt_s;
      end
   end

   // Read-valid pipeline: one cycle after a granted read, to its owner only.
   // Reset clears any read that was in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_rvalid_r <= 1'b0;
         l_rvalid_r <= 1'b0;
      end else begin
         c_rvalid_r <= c_gnt_s & ~c_we;
         l_rvalid_r <= l_gnt_s & ~l_we;
      end
   end

   // Stall counter: clear beats increment, saturates at 255.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_r <= 8'd0;
      end else if (cnt_clr) begin
         stall_cnt_r <= 8'd0;
      end else if (deny_s) begin
         stall_cnt_r <= sat_inc8(stall_cnt_r);
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign c_gnt     = c_gnt_s;
   assign l_gnt     = l_gnt_s;
   assign c_rvalid  = c_rvalid_r;
   assign l_rvalid  = l_rvalid_r;
   assign c_rdata   = m_rdata;
   assign l_rdata   = m_rdata;
   assign stall_cnt = stall_cnt_r;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_W, 8, data memory address width.
- DATA_W, 9, data word width (matches the 9-bit register/memory word).
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority with CPU highest.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- c_req  in  1  CPU access request.
- c_we  in  1  CPU write enable (0 = read).
- c_addr  in  ADDR_W  CPU address.
- c_wdata  in  DATA_W  CPU write data.
- c_gnt  out  1  CPU request accepted this cycle.
- c_rvalid  out  1  CPU read data valid.
- c_rdata  out  DATA_W  CPU read data.
- l_req, l_we, l_addr, l_wdata  in  1/1/ADDR_W/DATA_W  loader/debug port, same meaning as the CPU port.
- l_lock  in  1  loader requests exclusive ownership.
- l_gnt, l_rvalid, l_rdata  out  1/1/DATA_W  loader grant, read valid and read data.
- m_en, m_we  out  1/1  memory command strobe and write enable.
- m_addr, m_wdata  out  ADDR_W/DATA_W  memory address and write data.
- m_rdata  in  DATA_W  memory read data; synchronous, valid one cycle after m_en with m_we=0.
- stall_cnt  out  8  saturating count of denied-request cycles.
- cnt_clr  in  1  synchronous clear of stall_cnt.

Function
REQ-003 The block SHALL issue at most one memory command per cycle and SHALL set m_en = c_gnt | l_gnt, driven combinationally in the grant cycle.
REQ-004 m_we/m_addr/m_wdata SHALL come from the granted port; when m_en=0, m_we SHALL be 0.
REQ-005 A requester SHALL hold req/we/addr/wdata stable until its gnt; back-to-back requests on consecutive cycles SHALL each be grantable, giving one access per cycle throughput.
REQ-006 States: SHARED and LOCKED.
REQ-007 In SHARED, a sole requester SHALL be granted the same cycle.
REQ-008 On a SHARED conflict with RR_MODE=1, the grant SHALL go to the port not granted most recently.
- A last-owner register SHALL update on every grant.
REQ-009 On a SHARED conflict with RR_MODE=0, the CPU SHALL always win.
REQ-010 SHARED to LOCKED SHALL occur at the edge ending a cycle in which l_gnt=1 and l_lock=1.
REQ-011 In LOCKED, c_gnt SHALL be 0, and l_req SHALL be granted whenever asserted.
REQ-012 LOCKED to SHARED SHALL occur at the edge ending a cycle in which l_lock=0.
- The CPU SHALL remain blocked during that cycle.
REQ-013 For a granted read, the owner's rvalid SHALL assert exactly one cycle after the grant for one cycle, with rdata = m_rdata.
- The other port's rvalid SHALL stay 0.
REQ-014 c_rdata and l_rdata SHALL both equal m_rdata at all times; they are meaningful only with rvalid.
REQ-015 Writes SHALL produce no rvalid.
REQ-016 stall_cnt SHALL increment by 1 in every cycle in which any asserted request is not granted.
- It SHALL saturate at 255.
- cnt_clr SHALL take priority over increment and load 0.
REQ-017 No grant SHALL be issued while rst=1.

Reset
REQ-018 While rst=1, the block SHALL force the following immediately and asynchronously:
- c_gnt, l_gnt, m_en, m_we = 0.
- c_rvalid, l_rvalid = 0.
- state = SHARED.
- last-owner = loader, so the CPU wins the first round-robin conflict.
- stall_cnt = 0.
REQ-019 A read granted in the cycle before rst asserts SHALL NOT produce rvalid after reset.
- After rst deasserts, the first edge SHALL behave as SHARED with no pending reads.

Verification
REQ-020 CPU-only read: c_req=1, c_we=0, c_addr=0x10, memory holds 0x1A5 -> c_gnt=1 at cycle 0; c_rvalid=1 with c_rdata=0x1A5 at cycle 1; l_rvalid=0.
REQ-021 Round-robin conflict (RR_MODE=1): both ports request reads for 4 cycles from reset -> grants C,L,C,L; stall_cnt=4.
REQ-022 Fixed priority (RR_MODE=0): both ports request for 3 cycles -> c_gnt=1 every cycle, l_gnt=0; stall_cnt=3.
REQ-023 Lock sequence:
- Stimulus: loader writes 0x05 to address 0x20 with l_lock=1; loader then holds l_lock for 3 more cycles while c_req=1; l_lock drops.
- Response: c_gnt=0 through the cycle with l_lock=0; the CPU is granted the following cycle.
REQ-024 Saturation and clear: hold c_req=1 while locked for 300 cycles -> stall_cnt=255; cnt_clr=1 for one cycle -> stall_cnt=0 the next cycle.
REQ-025 Reset mid-read: CPU read granted, rst=1 on the next cycle -> c_rvalid=0 and stall_cnt=0; after release the state is SHARED and the CPU wins the first conflict.
